// File: rtl/seq_mult.sv
// Iterative shift-and-add multiplier, one partial product per clock.
// Signed mode multiplies magnitudes and negates the final sum when the operand signs differ.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] q
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    // Handshake: start is taken on a rising edge only while busy=0; busy then stays
    // high for WIDTH cycles, and done pulses for one cycle with q holding the new product.
    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand_sh;
    logic [WIDTH-1:0] mplier_sh;
    logic            neg;

    logic            accept;
    logic            last;
    logic [PW-1:0]   acc_sum;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        // The most negative operand negates to 2^(WIDTH-1), which fits as unsigned.
        abs_a      = (sgn && a[WIDTH-1]) ? -a : a;
        abs_b      = (sgn && b[WIDTH-1]) ? -b : b;
        acc_sum    = acc + (mplier_sh[0] ? mcand_sh : '0);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Multiplicand shifts left and multiplier shifts right each iteration, which is
    // the same as adding mcand << cnt whenever mplier[cnt] is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            q         <= '0;
            acc       <= '0;
            cnt       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            neg       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy      <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                mcand_sh  <= {{WIDTH{1'b0}}, abs_a};
                mplier_sh <= abs_b;
                neg       <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (state == RUN) begin
                acc       <= acc_sum;
                cnt       <= cnt + CW'(1);
                mcand_sh  <= mcand_sh << 1;
                mplier_sh <= mplier_sh >> 1;
                if (last) begin
                    q    <= neg ? -acc_sum : acc_sum;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: vector table at WIDTH=8, a WIDTH=4 instance, and
// hand-written sequences for ignored start, back-to-back issue and mid-run reset.
module tb_seq_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] q8;

    logic        start4 = 1'b0, sgn4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [7:0]  q4;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        string      name;
        logic       sgn;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] exp;
    } vec_t;

    seq_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .q(q8)
    );

    seq_mult #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .q(q4)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Issue one WIDTH=8 multiply; returns the product and the number of edges
    // from the accepting edge to the first sample with done=1 (40 means timeout).
    task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y,
                       output logic [15:0] res, output int lat);
        @(negedge clk);
        start8 = 1'b1; sgn8 = s; a8 = x; b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0; sgn8 = ~s;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = q8;
    endtask

    initial begin
        vec_t vecs[8];
        logic [15:0] res;
        logic [15:0] prev_q;
        int lat;
        int n_done;
        int done_at;
        int busy_cnt;
        logic [7:0] pa[4];
        logic [7:0] pb[4];
        logic [15:0] pe[4];

        vecs[0] = '{"u_ff_ff",     1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1] = '{"u_zero",      1'b0, 8'h00, 8'hC8, 16'h0000};
        vecs[2] = '{"s_m3_5",      1'b1, 8'hFD, 8'h05, 16'hFFF1};
        vecs[3] = '{"s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[4] = '{"s_m128_127",  1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[5] = '{"s_127_127",   1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[6] = '{"u_128_2",     1'b0, 8'h80, 8'h02, 16'h0100};
        vecs[7] = '{"s_m1_m1",     1'b1, 8'hFF, 8'hFF, 16'h0001};

        pa = '{8'd3, 8'd200, 8'd17, 8'd255};
        pb = '{8'd4, 8'd100, 8'd15, 8'd2};
        pe = '{16'd12, 16'd20000, 16'd255, 16'd510};

        // reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_q8", 32'(q8), 32'd0);
        check("rst_q4", 32'(q4), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=4: 15 x 12
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd15; b4 = 4'd12;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        busy_cnt = busy4 ? 1 : 0;
        n_done = 0; done_at = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (busy4) busy_cnt++;
            if (done4) begin
                n_done++;
                done_at = c;
                check("w4_q", 32'(q4), 32'd180);
            end
        end
        check("w4_busy_cycles", 32'(busy_cnt), 32'd4);
        check("w4_done_count", 32'(n_done), 32'd1);
        check("w4_done_edge", 32'(done_at), 32'd4);

        // vector table at WIDTH=8
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat);
            check({vecs[i].name, "_q"}, 32'(res), 32'(vecs[i].exp));
            check({vecs[i].name, "_lat"}, 32'(lat), 32'd8);
        end

        // start pulsed mid-run with different operands: ignored
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd7; b8 = 8'd9;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("ign_busy_e0", 32'(busy8), 32'd1);
        n_done = 0; done_at = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin
                start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; sgn8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                n_done++;
                done_at = c;
                check("ign_q", 32'(q8), 32'd63);
            end
        end
        check("ign_done_count", 32'(n_done), 32'd1);
        check("ign_done_edge", 32'(done_at), 32'd8);

        // back-to-back with start held high
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; a8 = pa[0]; b8 = pb[0];
        @(posedge clk); #1;
        exp_q.push_back(pe[0]);
        prev_q = 16'd63;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                a8 = pa[k+1]; b8 = pb[k+1];
            end else begin
                start8 = 1'b0;
            end
            for (int c = 1; c <= 9; c++) begin
                @(posedge clk); #1;
                if (c < 8) begin
                    check("b2b_done_low", 32'(done8), 32'd0);
                    check("b2b_q_hold", 32'(q8), 32'(prev_q));
                end else if (c == 8) begin
                    check("b2b_done", 32'(done8), 32'd1);
                    if (exp_q.size() > 0) prev_q = exp_q.pop_front();
                    check("b2b_q", 32'(q8), 32'(prev_q));
                end else begin
                    check("b2b_done_width", 32'(done8), 32'd0);
                    check("b2b_q_after", 32'(q8), 32'(prev_q));
                    if (k < 3) begin
                        check("b2b_reaccept", 32'(busy8), 32'd1);
                        exp_q.push_back(pe[k+1]);
                    end
                end
            end
        end

        // asynchronous reset at iteration 3
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd100; b8 = 8'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy8), 32'd0);
        check("arst_done", 32'(done8), 32'd0);
        check("arst_q", 32'(q8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done8) n_done++;
        end
        check("arst_no_done", 32'(n_done), 32'd0);
        op8(1'b0, 8'd6, 8'd7, res, lat);
        check("arst_fresh_q", 32'(res), 32'd42);
        check("arst_fresh_lat", 32'(lat), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised iterative shift-and-add multiplier: the sequential successor to the combinational 4x4 array multiplier. It supports any operand width and a per-operation signed/unsigned mode, and trades area for latency. It computes one partial product per clock and uses a start/busy/done handshake, so a controller or datapath FSM can issue multiplies without a wide combinational array in its timing path.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- start  input  1  request a multiply; sampled on a rising clk edge only while busy=0.
- sgn  input  1  mode, sampled with start: 0 = unsigned, 1 = two's-complement signed.
- a  input  WIDTH  multiplicand, sampled with start.
- b  input  WIDTH  multiplier, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; q holds a new valid result while done=1.
- q  output  2*WIDTH  product register; holds the last result until the next done.

## Operation
- States: IDLE, RUN. Iteration counter cnt is clog2(WIDTH+1) bits.
- IDLE with start=1 at an edge:
  - latch sgn, a and b; enter RUN with cnt=0; busy=1.
  - Unsigned: mcand=a, mplier=b.
  - Signed: mcand=|a| and mplier=|b|, each as a WIDTH-bit unsigned value (the most negative value maps to 2^(WIDTH-1), which is representable); neg = a[MSB] XOR b[MSB].
  - Accumulator acc (2*WIDTH bits) cleared to 0.
- RUN, each edge:
  - if mplier[cnt]=1, acc += mcand << cnt;
  - cnt += 1.
- RUN, edge on which cnt = WIDTH-1 (the final iteration):
  - q <= neg ? -(acc_final) : acc_final, truncated to 2*WIDTH bits;
  - done <= 1; busy <= 0; state -> IDLE.
- neg is forced to 0 in unsigned mode.
- Overflow is impossible: the full 2*WIDTH product is always exact.
- start while busy=1 is ignored, with no queueing and no effect on the running operation.
- a, b and sgn are don't-care except on the accepting edge. Changes during RUN do not affect the result.
- done is high for exactly one cycle. On any edge where done is not being set, done <= 0.
- Zero operands still take the full WIDTH iterations (fixed latency, no early exit).
- Reset mid-operation: state IDLE, busy=0, done=0, q=0, acc=0, cnt=0. The aborted operation never produces done.

## Timing
- Reset values: busy=0, done=0, q=0.
- Accepting edge E0: busy=1 immediately after E0.
- Iterations occur on edges E1..EWIDTH.
- After EWIDTH: done=1, busy=0, q valid. Latency is WIDTH cycles from the accepting edge to done.
- Back-to-back: start may be held high during the done cycle and is accepted at EWIDTH+1. Maximum throughput is one result per WIDTH+1 cycles.
- q changes only on the done-setting edge or on reset. It is stable through the following operation until its done.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=4, unsigned, a=15, b=12, start for 1 cycle:
  - busy high for 4 cycles;
  - done pulses once, 4 edges after acceptance;
  - q=180 (0xB4).
- WIDTH=8, unsigned:
  - a=255, b=255 -> q=65025 (0xFE01), done after 8 edges;
  - a=0, b=200 -> q=0, still 8-cycle latency.
- WIDTH=8, signed:
  - a=-3 (0xFD), b=5 -> q=0xFFF1 (-15);
  - a=-128, b=-128 -> q=0x4000 (16384);
  - a=-128, b=127 -> q=0xC080 (-16256).
- WIDTH=8, issue 7x9 and then pulse start again mid-RUN with a=1, b=1:
  - second start ignored;
  - single done with q=63;
  - a and b changed during RUN do not alter the result.
- Hold start=1 continuously with a new operand pair each accept:
  - results arrive every WIDTH+1 cycles;
  - each done is exactly one cycle;
  - q holds between dones.
- Assert rst asynchronously (between edges) at iteration 3 of a WIDTH=8 operation:
  - busy, done and q go to 0 immediately;
  - no done follows;
  - a fresh start after rst deasserts gives the correct product.
